// File: rtl/fx_bus_arb.sv
// fx_bus_arb -- two-master arbiter for the shared fx register bus.
//
// Grants one single-beat read or write at a time to either m0 (host bridge)
// or m1 (sequencer/debug master), drives the fx strobes/addresses/data, and
// returns read data taken from the OR-combined slave return bus fx_q.
//
// Ports:
//   clk_sys, rst               system clock, asynchronous active-high reset
//   mX_req/we/addr/wdata       master X request (level, held until mX_ack)
//   mX_ack                     one-cycle completion pulse for master X
//   mX_rdata                   read data for master X, valid with mX_ack
//   fx_wr/fx_waddr/fx_data     fx write strobe, address and data
//   fx_rd/fx_raddr             fx read strobe and address
//   fx_q                       OR-combined slave read data
//   busy                       high whenever the arbiter is not idle
//
// Parameters:
//   RD_LAT   cycles from the fx_rd strobe cycle to valid fx_q (1..7)
//   FIX_PRI  0 = round-robin on ties, 1 = m0 always wins a tie

module fx_bus_arb #(
  parameter int unsigned RD_LAT  = 1,
  parameter bit          FIX_PRI = 1'b0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic        fx_wr,
  output logic [15:0] fx_waddr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [15:0] fx_raddr,
  input  logic [7:0]  fx_q,
  output logic        busy
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;          // 0 = m0, 1 = m1
  logic        we_q, we_d;
  logic        last_gnt_q, last_gnt_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fx_wr_q, fx_wr_d;
  logic        fx_rd_q, fx_rd_d;
  logic [15:0] fx_waddr_q, fx_waddr_d;
  logic [15:0] fx_raddr_q, fx_raddr_d;
  logic [7:0]  fx_data_q, fx_data_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [7:0]  m0_rdata_q, m0_rdata_d;
  logic [7:0]  m1_rdata_q, m1_rdata_d;
  logic        busy_q, busy_d;

  logic        sel_s;
  logic        sel_we_s;
  logic [15:0] sel_addr_s;
  logic [7:0]  sel_wdata_s;

  // Pick the master to grant if the arbiter is idle, and mux its request.
  always_comb begin
    sel_s = 1'b0;
    if (m0_req && m1_req) begin
      // Round-robin favours whichever master did not win last time.
      sel_s = FIX_PRI ? 1'b0 : ~last_gnt_q;
    end else if (m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    sel_we_s    = sel_s ? m1_we    : m0_we;
    sel_addr_s  = sel_s ? m1_addr  : m0_addr;
    sel_wdata_s = sel_s ? m1_wdata : m0_wdata;
  end

  // Next-state and next-output logic; all outputs are registered, so each
  // output value is computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    fx_wr_d    = 1'b0;
    fx_rd_d    = 1'b0;
    fx_waddr_d = fx_waddr_q;
    fx_raddr_d = fx_raddr_q;
    fx_data_d  = fx_data_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d      = sel_s;
          we_d       = sel_we_s;
          last_gnt_d = sel_s;
          state_d    = CMD;
          if (sel_we_s) begin
            fx_wr_d    = 1'b1;
            fx_waddr_d = sel_addr_s;
            fx_data_d  = sel_wdata_s;
          end else begin
            fx_rd_d    = 1'b1;
            fx_raddr_d = sel_addr_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (we_q) begin
          state_d  = ACK;
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
        end else begin
          state_d = RWAIT;
          cnt_d   = RD_LAT_C;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - 3'd1;
        // fx_q is valid in the cycle the counter reaches 1.
        if (cnt_q <= 3'd1) begin
          state_d  = ACK;
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
          if (gnt_q) begin
            m1_rdata_d = fx_q;
          end else begin
            m0_rdata_d = fx_q;
          end
        end else begin
          state_d = RWAIT;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= 3'd0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      fx_waddr_q <= 16'h0000;
      fx_raddr_q <= 16'h0000;
      fx_data_q  <= 8'h00;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 8'h00;
      m1_rdata_q <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      fx_wr_q    <= fx_wr_d;
      fx_rd_q    <= fx_rd_d;
      fx_waddr_q <= fx_waddr_d;
      fx_raddr_q <= fx_raddr_d;
      fx_data_q  <= fx_data_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign fx_wr    = fx_wr_q;
  assign fx_rd    = fx_rd_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_data  = fx_data_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// tb_fx_bus_arb -- self-checking bench for fx_bus_arb.
//
// Two arbiters share the clock and reset: bus 0 is round-robin with RD_LAT=1,
// bus 1 is fixed-priority with RD_LAT=3. Each bus has a slave model with
// mod_id 3 (registers reset to their own index); all other modules read 0.
// A transaction-level timeline model predicts grant order, strobe/ack
// cycles, addresses, and read data.

module tb_fx_bus_arb;

  logic        clk_sys;
  logic        rst;
  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [15:0] addr_s  [2][2];
  logic [7:0]  wdata_s [2][2];
  logic        ack_s   [2][2];
  logic [7:0]  rdata_s [2][2];
  logic        fx_wr_s    [2];
  logic        fx_rd_s    [2];
  logic [15:0] fx_waddr_s [2];
  logic [15:0] fx_raddr_s [2];
  logic [7:0]  fx_data_s  [2];
  logic [7:0]  fx_q_s     [2];
  logic        busy_s     [2];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  fx_bus_arb #(.RD_LAT(1), .FIX_PRI(1'b0)) u_dut0 (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(req_s[0][0]), .m0_we(we_s[0][0]), .m0_addr(addr_s[0][0]), .m0_wdata(wdata_s[0][0]),
    .m0_ack(ack_s[0][0]), .m0_rdata(rdata_s[0][0]),
    .m1_req(req_s[0][1]), .m1_we(we_s[0][1]), .m1_addr(addr_s[0][1]), .m1_wdata(wdata_s[0][1]),
    .m1_ack(ack_s[0][1]), .m1_rdata(rdata_s[0][1]),
    .fx_wr(fx_wr_s[0]), .fx_waddr(fx_waddr_s[0]), .fx_data(fx_data_s[0]),
    .fx_rd(fx_rd_s[0]), .fx_raddr(fx_raddr_s[0]), .fx_q(fx_q_s[0]), .busy(busy_s[0])
  );

  fx_bus_arb #(.RD_LAT(3), .FIX_PRI(1'b1)) u_dut1 (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(req_s[1][0]), .m0_we(we_s[1][0]), .m0_addr(addr_s[1][0]), .m0_wdata(wdata_s[1][0]),
    .m0_ack(ack_s[1][0]), .m0_rdata(rdata_s[1][0]),
    .m1_req(req_s[1][1]), .m1_we(we_s[1][1]), .m1_addr(addr_s[1][1]), .m1_wdata(wdata_s[1][1]),
    .m1_ack(ack_s[1][1]), .m1_rdata(rdata_s[1][1]),
    .fx_wr(fx_wr_s[1]), .fx_waddr(fx_waddr_s[1]), .fx_data(fx_data_s[1]),
    .fx_rd(fx_rd_s[1]), .fx_raddr(fx_raddr_s[1]), .fx_q(fx_q_s[1]), .busy(busy_s[1])
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Slave models: mod_id 3 register file, registered read data delayed RD_LAT.
  logic [7:0] smem [2][256];
  logic [7:0] pipe [2][8];
  always @(posedge clk_sys) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 256; r++) smem[k][r] <= 8'(r);
      end else if (fx_wr_s[k] && fx_waddr_s[k][13:8] == 6'd3) begin
        smem[k][fx_waddr_s[k][7:0]] <= fx_data_s[k];
      end
      pipe[k][0] <= (fx_rd_s[k] && fx_raddr_s[k][13:8] == 6'd3) ? smem[k][fx_raddr_s[k][7:0]] : 8'h00;
      for (int j = 1; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end
  assign fx_q_s[0] = pipe[0][0];
  assign fx_q_s[1] = pipe[1][2];

  // Reference model state.
  logic [7:0]  exp_mem  [2][256];
  logic [7:0]  erd      [2][2];
  logic [15:0] ew       [2];
  logic [15:0] er       [2];
  logic [7:0]  ed       [2];
  logic        exp_last [2];

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;
  txn_t tq [2][32];
  int   qh [2];
  int   qt [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit fixp_of(input int k);
    return (k == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_last[k] = 1'b1;
      ew[k] = 16'h0000; er[k] = 16'h0000; ed[k] = 8'h00;
      for (int m = 0; m < 2; m++) erd[k][m] = 8'h00;
      for (int r = 0; r < 256; r++) exp_mem[k][r] = 8'(r);
    end
  endtask

  task automatic enq(input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
    tq[m][qt[m]] = '{we, a, d};
    qt[m]++;
  endtask

  // Drive the queued transactions on bus k and check every cycle against the
  // timeline model. gap_pct is the chance per cycle of a master delaying its request.
  task automatic run_bus(input int k, input int gap_pct);
    int   now, free_at, grant_at, strobe_at, ack_at;
    bit   active, cm, done;
    bit   raised [2];
    bit   justack [2];
    txn_t ct;
    now = 0; free_at = 0; grant_at = -1; strobe_at = -1; ack_at = -1;
    active = 1'b0; cm = 1'b0; done = 1'b0; ct = '0;
    raised[0] = 1'b0; raised[1] = 1'b0; justack[0] = 1'b0; justack[1] = 1'b0;
    while (now < 600) begin
      if (active && now == strobe_at) begin
        if (ct.we) begin ew[k] = ct.addr; ed[k] = ct.wdata; end
        else er[k] = ct.addr;
      end
      if (active && now == ack_at && !ct.we)
        erd[k][cm] = (ct.addr[13:8] == 6'd3) ? exp_mem[k][ct.addr[7:0]] : 8'h00;

      chk($sformatf("b%0d fx_wr t%0d", k, now), 32'(fx_wr_s[k]), 32'(active && now == strobe_at && ct.we));
      chk($sformatf("b%0d fx_rd t%0d", k, now), 32'(fx_rd_s[k]), 32'(active && now == strobe_at && !ct.we));
      chk($sformatf("b%0d busy t%0d", k, now), 32'(busy_s[k]), 32'(active && now > grant_at && now <= ack_at));
      chk($sformatf("b%0d fx_waddr t%0d", k, now), 32'(fx_waddr_s[k]), 32'(ew[k]));
      chk($sformatf("b%0d fx_data t%0d", k, now), 32'(fx_data_s[k]), 32'(ed[k]));
      chk($sformatf("b%0d fx_raddr t%0d", k, now), 32'(fx_raddr_s[k]), 32'(er[k]));
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("b%0d m%0d_ack t%0d", k, m, now), 32'(ack_s[k][m]),
            32'(active && now == ack_at && int'(cm) == m));
        chk($sformatf("b%0d m%0d_rdata t%0d", k, m, now), 32'(rdata_s[k][m]), 32'(erd[k][m]));
      end

      if (active && now == ack_at) begin
        req_s[k][cm] = 1'b0;
        raised[cm]   = 1'b0;
        justack[cm]  = 1'b1;
        qh[cm]++;
        active  = 1'b0;
        free_at = now + 1;
      end

      for (int m = 0; m < 2; m++) begin
        if (!raised[m] && !justack[m] && qh[m] < qt[m] && int'($urandom_range(99)) >= gap_pct) begin
          we_s[k][m]    = tq[m][qh[m]].we;
          addr_s[k][m]  = tq[m][qh[m]].addr;
          wdata_s[k][m] = tq[m][qh[m]].wdata;
          req_s[k][m]   = 1'b1;
          raised[m]     = 1'b1;
        end
        justack[m] = 1'b0;
      end

      if (!active && now >= free_at && (raised[0] || raised[1])) begin
        if (raised[0] && raised[1]) cm = fixp_of(k) ? 1'b0 : ~exp_last[k];
        else cm = raised[1];
        exp_last[k] = cm;
        ct        = tq[cm][qh[cm]];
        grant_at  = now;
        strobe_at = now + 1;
        ack_at    = ct.we ? now + 2 : now + 2 + lat_of(k);
        active    = 1'b1;
        if (ct.we && ct.addr[13:8] == 6'd3) exp_mem[k][ct.addr[7:0]] = ct.wdata;
      end

      if (!active && !raised[0] && !raised[1] && qh[0] == qt[0] && qh[1] == qt[1] && now >= free_at) begin
        done = 1'b1;
        break;
      end
      @(posedge clk_sys); #1;
      now++;
    end
    chk($sformatf("b%0d run_complete", k), 32'(done), 32'd1);
    for (int m = 0; m < 2; m++) begin
      req_s[k][m] = 1'b0; qh[m] = 0; qt[m] = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        req_s[k][m] = 1'b0; we_s[k][m] = 1'b0; addr_s[k][m] = 16'h0000; wdata_s[k][m] = 8'h00;
      end
    end
    qh[0] = 0; qh[1] = 0; qt[0] = 0; qt[1] = 0;
    model_reset();

    // Reset values.
    @(posedge clk_sys); @(posedge clk_sys); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("b%0d rst fx_wr", k), 32'(fx_wr_s[k]), 32'd0);
      chk($sformatf("b%0d rst fx_rd", k), 32'(fx_rd_s[k]), 32'd0);
      chk($sformatf("b%0d rst fx_waddr", k), 32'(fx_waddr_s[k]), 32'd0);
      chk($sformatf("b%0d rst fx_raddr", k), 32'(fx_raddr_s[k]), 32'd0);
      chk($sformatf("b%0d rst fx_data", k), 32'(fx_data_s[k]), 32'd0);
      chk($sformatf("b%0d rst busy", k), 32'(busy_s[k]), 32'd0);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("b%0d rst m%0d_ack", k, m), 32'(ack_s[k][m]), 32'd0);
        chk($sformatf("b%0d rst m%0d_rdata", k, m), 32'(rdata_s[k][m]), 32'd0);
      end
    end
    rst = 1'b0;

    // Bus 0: m1 read of a reset register, m0 write then read-back.
    enq(1, 1'b0, 16'h0382, 8'h00); run_bus(0, 0);
    enq(0, 1'b1, 16'h0381, 8'h5A); run_bus(0, 0);
    enq(1, 1'b0, 16'h0381, 8'h00); run_bus(0, 0);

    // Bus 0: both masters held continuously -> alternating grants.
    for (int i = 0; i < 3; i++) begin
      enq(0, 1'(i % 2), 16'h0390 + 16'(i), 8'h10 + 8'(i));
      enq(1, 1'((i + 1) % 2), 16'h0390 + 16'(i), 8'h20 + 8'(i));
    end
    run_bus(0, 0);

    // Bus 1: unmapped read with RD_LAT=3, then fixed-priority contention.
    enq(0, 1'b0, 16'h0500, 8'h00); run_bus(1, 0);
    for (int i = 0; i < 3; i++) enq(0, 1'b1, 16'h03A0 + 16'(i), 8'hC0 + 8'(i));
    enq(1, 1'b0, 16'h03A1, 8'h00);
    enq(1, 1'b0, 16'h0382, 8'h00);
    run_bus(1, 0);

    // Reset in the middle of a bus-0 read (RWAIT cycle).
    we_s[0][0] = 1'b0; addr_s[0][0] = 16'h0381; req_s[0][0] = 1'b1;
    @(posedge clk_sys); #1;
    chk("mid fx_rd in CMD", 32'(fx_rd_s[0]), 32'd1);
    @(posedge clk_sys); #1;
    chk("mid busy in RWAIT", 32'(busy_s[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst fx_rd", 32'(fx_rd_s[0]), 32'd0);
    chk("mid rst busy", 32'(busy_s[0]), 32'd0);
    chk("mid rst m0_ack", 32'(ack_s[0][0]), 32'd0);
    chk("mid rst m0_rdata", 32'(rdata_s[0][0]), 32'd0);
    req_s[0][0] = 1'b0;
    @(posedge clk_sys); #1;
    chk("mid rst m0_ack held", 32'(ack_s[0][0]), 32'd0);
    rst = 1'b0;
    model_reset();
    @(posedge clk_sys); #1;
    chk("post rst m0_ack", 32'(ack_s[0][0]), 32'd0);

    // First tie after reset goes to m0.
    enq(0, 1'b0, 16'h0381, 8'h00);
    enq(1, 1'b0, 16'h0383, 8'h00);
    run_bus(0, 0);

    // Randomized traffic on both buses.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 24; i++) begin
        int          m;
        logic [5:0]  mod;
        logic [15:0] a;
        m   = int'($urandom_range(1));
        mod = ($urandom_range(3) == 0) ? 6'd5 : 6'd3;
        a   = {2'b00, mod, 8'h80 + 8'($urandom_range(7))};
        enq(m, 1'($urandom_range(1)), a, 8'($urandom));
      end
      run_bus(k, 40);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
